// File: rtl/config_frame_rx.sv
// Configuration frame receiver: assembles address/data packets from a byte stream,
// optionally verifies a trailing checksum, and presents a held register write.
//
// state       | meaning
// ST_ADDR     | collecting address packets (count = packets received so far)
// ST_DATA     | collecting data packets
// ST_CHK      | waiting for the checksum packet
// ST_WAIT_ACK | committed write pending, input stalled until register_ack
module config_frame_rx #(
    parameter int RX_DATA_WIDTH    = 8,
    parameter int REG_ADDR_PACKETS = 2,
    parameter int REG_DATA_PACKETS = 4,
    parameter int MSB_FIRST        = 0,
    parameter int CHECKSUM_EN      = 1,
    parameter int TIMEOUT_CYCLES   = 1000
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [RX_DATA_WIDTH-1:0]                   rx_data,
    input  logic                                       rx_rdy,
    output logic                                       rx_ack,
    output logic [REG_ADDR_PACKETS*RX_DATA_WIDTH-1:0]  register_addr,
    output logic [REG_DATA_PACKETS*RX_DATA_WIDTH-1:0]  register_data,
    output logic                                       register_rdy,
    input  logic                                       register_ack,
    output logic                                       err_checksum,
    output logic                                       err_timeout
);

    localparam int REG_ADDR_WIDTH = REG_ADDR_PACKETS * RX_DATA_WIDTH;
    localparam int REG_DATA_WIDTH = REG_DATA_PACKETS * RX_DATA_WIDTH;
    localparam int MAX_PKTS = (REG_ADDR_PACKETS > REG_DATA_PACKETS) ? REG_ADDR_PACKETS : REG_DATA_PACKETS;
    localparam int CNT_W    = (MAX_PKTS > 1) ? $clog2(MAX_PKTS) : 1;
    localparam int IDLE_W   = (TIMEOUT_CYCLES > 0) ? (($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1) : 1;

    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(REG_ADDR_PACKETS - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(REG_DATA_PACKETS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_ADDR     = 2'd0,
        ST_DATA     = 2'd1,
        ST_CHK      = 2'd2,
        ST_WAIT_ACK = 2'd3
    } state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          count;
    logic [IDLE_W-1:0]         idle_cnt;
    logic [RX_DATA_WIDTH-1:0]  sum;
    logic [REG_ADDR_WIDTH-1:0] shadow_addr, sa_nxt;
    logic [REG_DATA_WIDTH-1:0] shadow_data, sd_nxt;
    logic                      accept, in_frame, timeout_hit;
    logic                      field_last, commit, bad_chk;

    assign accept   = rx_ack;
    // A frame is in progress once its first packet is taken and until commit.
    assign in_frame = (state == ST_DATA) || (state == ST_CHK) || ((state == ST_ADDR) && (count != '0));
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && in_frame && !accept && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_ADDR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        field_last = 1'b0;
        commit     = 1'b0;
        bad_chk    = 1'b0;
        case (state)
            ST_ADDR: begin
                field_last = (count == ADDR_LAST);
                if (accept && field_last) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                field_last = (count == DATA_LAST);
                if (accept && field_last) begin
                    if (CHECKSUM_EN != 0) begin
                        state_nxt = ST_CHK;
                    end else begin
                        state_nxt = ST_WAIT_ACK;
                        commit    = 1'b1;
                    end
                end
            end
            ST_CHK: begin
                field_last = 1'b1;
                if (accept) begin
                    if (rx_data == sum) begin
                        state_nxt = ST_WAIT_ACK;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = ST_ADDR;
                        bad_chk   = 1'b1;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (register_ack) state_nxt = ST_ADDR;
            end
            default: state_nxt = ST_ADDR;
        endcase
        if (timeout_hit) state_nxt = ST_ADDR;
    end

    always_comb begin
        rx_ack = rx_rdy && (state != ST_WAIT_ACK);
    end

    // Shadow update including the packet consumed this cycle, so commit can use it directly.
    always_comb begin
        int addr_slot;
        int data_slot;
        sa_nxt    = shadow_addr;
        sd_nxt    = shadow_data;
        addr_slot = (MSB_FIRST != 0) ? (REG_ADDR_PACKETS - 1 - int'(count)) : int'(count);
        data_slot = (MSB_FIRST != 0) ? (REG_DATA_PACKETS - 1 - int'(count)) : int'(count);
        for (int i = 0; i < REG_ADDR_PACKETS; i++) begin
            if (accept && (state == ST_ADDR) && (i == addr_slot))
                sa_nxt[i*RX_DATA_WIDTH +: RX_DATA_WIDTH] = rx_data;
        end
        for (int i = 0; i < REG_DATA_PACKETS; i++) begin
            if (accept && (state == ST_DATA) && (i == data_slot))
                sd_nxt[i*RX_DATA_WIDTH +: RX_DATA_WIDTH] = rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= '0;
            idle_cnt      <= '0;
            sum           <= '0;
            shadow_addr   <= '0;
            shadow_data   <= '0;
            register_addr <= '0;
            register_data <= '0;
            register_rdy  <= 1'b0;
            err_checksum  <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            err_checksum <= bad_chk;
            err_timeout  <= timeout_hit;

            if (bad_chk || timeout_hit) begin
                shadow_addr <= '0;
                shadow_data <= '0;
            end else begin
                shadow_addr <= sa_nxt;
                shadow_data <= sd_nxt;
            end

            if (bad_chk || timeout_hit || commit)
                sum <= '0;
            else if (accept && ((state == ST_ADDR) || (state == ST_DATA)))
                sum <= sum + rx_data;

            if (timeout_hit)
                count <= '0;
            else if (accept && (state != ST_CHK))
                count <= field_last ? '0 : count + 1'b1;

            if (accept || !in_frame || timeout_hit || (TIMEOUT_CYCLES == 0))
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;

            if (commit) begin
                register_addr <= sa_nxt;
                register_data <= sd_nxt;
                register_rdy  <= 1'b1;
            end else if ((state == ST_WAIT_ACK) && register_ack) begin
                register_rdy  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/config_frame_rx.md
Name: config_frame_rx

Overview:
- Receives configuration frames from the serial/FIFO byte stream (simple rdy/ack interface) and presents complete address/data register writes on a second rdy/ack interface.
- Next-generation receiver: generic packet counts, selectable packet order, optional checksum, inter-packet timeout resynchronisation, and output registers that stay stable while a new frame is captured.
- Sits between the communication RX FIFO and the configuration register bank.

Parameters:
- RX_DATA_WIDTH, 8, width of one packet.
- REG_ADDR_PACKETS, 2, packets per address (>=1); REG_ADDR_WIDTH = REG_ADDR_PACKETS*RX_DATA_WIDTH (localparam).
- REG_DATA_PACKETS, 4, packets per data word (>=1); REG_DATA_WIDTH = REG_DATA_PACKETS*RX_DATA_WIDTH (localparam).
- MSB_FIRST, 0, 0 = first packet goes to bits [RX_DATA_WIDTH-1:0]; 1 = first packet goes to the top slice.
- CHECKSUM_EN, 1, 1 = one checksum packet follows the data packets.
- TIMEOUT_CYCLES, 1000, idle cycles before a partial frame is aborted; 0 disables the timeout.

Ports:
- clk  in  1  fpga clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  RX_DATA_WIDTH  incoming packet.
- rx_rdy  in  1  packet available.
- rx_ack  out  1  packet consumed (combinational).
- register_addr  out  REG_ADDR_WIDTH  committed address.
- register_data  out  REG_DATA_WIDTH  committed data.
- register_rdy  out  1  committed write pending.
- register_ack  in  1  write taken by consumer.
- err_checksum  out  1  one-cycle pulse: frame discarded, bad checksum.
- err_timeout  out  1  one-cycle pulse: frame discarded, timeout.

Behaviour:
- Reset (async, rst=1):
  - state=ST_ADDR, packet count=0, idle counter=0, running sum=0.
  - register_addr=0, register_data=0, register_rdy=0, err_checksum=0, err_timeout=0.
  - Takes effect immediately, mid-frame included; the partial frame is lost.
- Acceptance:
  - rx_ack = rx_rdy when state is ST_ADDR, ST_DATA or ST_CHK; rx_ack = 0 in ST_WAIT_ACK.
  - A packet is consumed on any rising edge where rx_rdy && rx_ack.
- Capture:
  - Packets are written into shadow address/data registers at slice index k (k = arrival index within the field), or at index PACKETS-1-k when MSB_FIRST=1.
  - register_addr/register_data change only at commit.
- States:
  - ST_ADDR: accept REG_ADDR_PACKETS packets, then go to ST_DATA with count=0.
  - ST_DATA: accept REG_DATA_PACKETS packets. On the last one, go to ST_CHK if CHECKSUM_EN=1, otherwise commit.
  - ST_CHK:
    - Accept one packet.
    - If it equals the running sum (mod 2^RX_DATA_WIDTH of all addr and data packets of this frame), commit.
    - Otherwise pulse err_checksum for one cycle, go to ST_ADDR and discard the shadows.
  - Commit (same edge as the last accepted packet): copy shadows to the outputs, set register_rdy=1, go to ST_WAIT_ACK.
  - ST_WAIT_ACK:
    - On register_ack=1, set register_rdy=0 and go to ST_ADDR.
    - Outputs hold until the next commit.
    - The earliest next packet is accepted one cycle after the ack.
- Running sum: cleared at frame start and on every abort/commit; it accumulates each addr/data packet as it is consumed.
- Latency: register_rdy rises on the edge that consumes the final packet of the frame (the checksum packet, or the last data packet when CHECKSUM_EN=0).
- Timeout (TIMEOUT_CYCLES>0):
  - Applies while a frame is in progress: at least one packet accepted and state is not ST_WAIT_ACK.
  - The idle counter increments on each edge with no acceptance and clears on acceptance.
  - On the TIMEOUT_CYCLES-th consecutive idle edge: pulse err_timeout, go to ST_ADDR, set count=0 and clear the sum.
  - Acceptance on the same edge wins over timeout.
  - No timeout in ST_ADDR with count=0 or in ST_WAIT_ACK.
- Counter widths:
  - The count register is sized max(1, clog2(max(REG_ADDR_PACKETS, REG_DATA_PACKETS))).
  - The idle counter is sized max(1, clog2(TIMEOUT_CYCLES+1)).
  - No wrap occurs in normal use.
- Degenerate cases:
  - REG_*_PACKETS=1: the field completes on a single packet.
  - The error pulses are mutually exclusive and never coincide with a commit.

Test Plan:
- Defaults, stream 34 12 78 56 34 12 5A with rx_rdy held high -> 7 consecutive acks. register_rdy rises on the 7th edge with addr=0x1234, data=0x12345678. rx_ack=0 until register_ack, then returns to ST_ADDR.
- Same stream with checksum 5B -> err_checksum pulses for 1 cycle, register_rdy stays 0, outputs remain at reset/previous values. A following correct frame commits normally.
- MSB_FIRST=1, CHECKSUM_EN=0, stream 12 34 12 34 56 78 -> addr=0x1234, data=0x12345678, register_rdy on the 6th edge.
- TIMEOUT_CYCLES=10, send 3 packets then idle 10 cycles -> err_timeout pulses on the 10th idle edge. The next 7-packet frame is parsed from the addr field. An idle gap of 9 cycles does not abort.
- Hold register_ack=0 for 50 cycles with rx_rdy=1 -> rx_ack=0 throughout and outputs stable. Assert ack -> rdy falls, next packet accepted the following cycle.
- Assert rst mid-data (after 4 packets) -> all outputs 0 immediately, without waiting for a clock edge. The next frame decodes correctly.
